// File: rtl/lock_pkg.sv
// Shared key codes and FSM encoding for the keypad lock controller.
package lock_pkg;

   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_CLEAR = 4'hB;
   localparam logic [3:0] KEY_PROG  = 4'hC;

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      PROGRAM,
      COMPARE,
      RESULT,
      UNLOCKED,
      LOCKOUT
   } state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done pulses for the single cycle in which the count reads one.
module lock_timer #(
   parameter int WIDTH = 28
) (
   input  logic             clk,
   input  logic             input_reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge input_reset) begin
      if (!input_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // A load of N gives exactly N cycles before the owner sees done.
   assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/lock_controller.sv
// Keypad lock sequencer: collects digits, strobes an external code checker,
// and manages unlock hold time, failure counting and lockout.
module lock_controller
   import lock_pkg::*;
#(
   parameter int MAX_DIGITS     = 4,
   parameter int MAX_FAILS      = 3,
   parameter int UNLOCK_CYCLES  = 50_000_000,
   parameter int LOCKOUT_CYCLES = 250_000_000
) (
   input  logic       clk,
   input  logic       input_reset,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       correct_password,
   input  logic       incorrect_password,
   output logic [3:0] bits,
   output logic       input_value,
   output logic       store_value,
   output logic       compare,
   output logic       clear_n,
   output logic       unlocked,
   output logic       locked_out,
   output logic [1:0] fail_count
);

   localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int TW      = $clog2(TMR_MAX + 1);
   localparam int CW      = $clog2(MAX_DIGITS + 1);
   localparam logic [CW-1:0] DIGIT_LIMIT = CW'(MAX_DIGITS);
   localparam logic [1:0]    FAIL_LIMIT  = 2'(MAX_FAILS);

   state_t        state_q, state_d;
   logic [3:0]    bits_q, bits_d;
   logic          in_q, in_d;
   logic          st_q, st_d;
   logic          clear_n_q, clear_n_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    phase_q, phase_d;
   logic [1:0]    fail_q, fail_d;
   logic [1:0]    fail_inc;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_done;
   logic          key_ok, digit_key, enter_key, clear_key, prog_key;

   // Keys arriving while a strobe is on the bus are discarded outright.
   assign key_ok    = key_valid && !in_q && !st_q;
   assign digit_key = key_ok && is_digit(key_code);
   assign enter_key = key_ok && (key_code == KEY_ENTER);
   assign clear_key = key_ok && (key_code == KEY_CLEAR);
   assign prog_key  = key_ok && (key_code == KEY_PROG);
   assign fail_inc  = (fail_q >= FAIL_LIMIT) ? fail_q : fail_q + 2'd1;

   always_comb begin
      state_d   = state_q;
      bits_d    = bits_q;
      in_d      = 1'b0;
      st_d      = 1'b0;
      clear_n_d = 1'b1;
      cnt_d     = cnt_q;
      phase_d   = phase_q;
      fail_d    = fail_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      case (state_q)
         IDLE: begin
            if (digit_key) begin
               state_d = ENTRY;
               bits_d  = key_code;
               in_d    = 1'b1;
               cnt_d   = CW'(1);
            end
         end
         ENTRY: begin
            if (digit_key) begin
               if (cnt_q < DIGIT_LIMIT) begin
                  bits_d = key_code;
                  in_d   = 1'b1;
                  cnt_d  = cnt_q + CW'(1);
               end
            end else if (enter_key) begin
               if (cnt_q != '0) begin
                  state_d = COMPARE;
                  phase_d = 2'd0;
               end
            end else if (clear_key) begin
               clear_n_d = 1'b0;
               cnt_d     = '0;
            end
         end
         PROGRAM: begin
            if (digit_key) begin
               if (cnt_q < DIGIT_LIMIT) begin
                  bits_d = key_code;
                  st_d   = 1'b1;
                  cnt_d  = cnt_q + CW'(1);
               end
            end else if (enter_key) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (clear_key) begin
               clear_n_d = 1'b0;
               cnt_d     = '0;
            end
         end
         COMPARE: begin
            if (phase_q == 2'd1) begin
               state_d = RESULT;
               phase_d = 2'd0;
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end
         RESULT: begin
            // Silence from the checker for four cycles is treated as a wrong code.
            if (correct_password) begin
               state_d   = UNLOCKED;
               fail_d    = 2'd0;
               tmr_load  = 1'b1;
               tmr_val   = TW'(UNLOCK_CYCLES);
               clear_n_d = 1'b0;
               cnt_d     = '0;
            end else if (incorrect_password || (phase_q == 2'd3)) begin
               fail_d    = fail_inc;
               clear_n_d = 1'b0;
               cnt_d     = '0;
               if (fail_inc == FAIL_LIMIT) begin
                  state_d  = LOCKOUT;
                  tmr_load = 1'b1;
                  tmr_val  = TW'(LOCKOUT_CYCLES);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end
         UNLOCKED: begin
            if (tmr_done || enter_key) begin
               state_d = IDLE;
            end else if (prog_key) begin
               state_d   = PROGRAM;
               clear_n_d = 1'b0;
               cnt_d     = '0;
            end
         end
         LOCKOUT: begin
            if (tmr_done) begin
               state_d = IDLE;
               fail_d  = 2'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge input_reset) begin
      if (!input_reset) begin
         state_q   <= IDLE;
         bits_q    <= 4'd0;
         in_q      <= 1'b0;
         st_q      <= 1'b0;
         clear_n_q <= 1'b0;
         cnt_q     <= '0;
         phase_q   <= 2'd0;
         fail_q    <= 2'd0;
      end else begin
         state_q   <= state_d;
         bits_q    <= bits_d;
         in_q      <= in_d;
         st_q      <= st_d;
         clear_n_q <= clear_n_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         fail_q    <= fail_d;
      end
   end

   lock_timer #(
      .WIDTH(TW)
   ) u_timer (
      .clk        (clk),
      .input_reset(input_reset),
      .load       (tmr_load),
      .load_val   (tmr_val),
      .done       (tmr_done)
   );

   assign bits        = bits_q;
   assign input_value = in_q;
   assign store_value = st_q;
   assign compare     = (state_q == COMPARE);
   assign clear_n     = clear_n_q;
   assign unlocked    = (state_q == UNLOCKED);
   assign locked_out  = (state_q == LOCKOUT);
   assign fail_count  = fail_q;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller with short unlock/lockout windows.
module tb_lock_controller;
   import lock_pkg::*;

   logic       clk = 1'b0;
   logic       input_reset;
   logic       key_valid;
   logic [3:0] key_code;
   logic       correct_password;
   logic       incorrect_password;
   logic [3:0] bits;
   logic       input_value, store_value, compare, clear_n;
   logic       unlocked, locked_out;
   logic [1:0] fail_count;

   int vec_cnt = 0;
   int err_cnt = 0;

   lock_controller #(
      .MAX_DIGITS    (4),
      .MAX_FAILS     (3),
      .UNLOCK_CYCLES (20),
      .LOCKOUT_CYCLES(30)
   ) dut (
      .clk               (clk),
      .input_reset       (input_reset),
      .key_valid         (key_valid),
      .key_code          (key_code),
      .correct_password  (correct_password),
      .incorrect_password(incorrect_password),
      .bits              (bits),
      .input_value       (input_value),
      .store_value       (store_value),
      .compare           (compare),
      .clear_n           (clear_n),
      .unlocked          (unlocked),
      .locked_out        (locked_out),
      .fail_count        (fail_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Checker strobes must never overlap.
   always @(negedge clk) begin
      if (input_reset === 1'b1)
         check_eq("strobe_mutex", 32'(input_value) + 32'(store_value) + 32'(compare) <= 1, 1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_digit(input logic [3:0] d, input logic [3:0] exp_bits,
                              input logic exp_in, input logic exp_st);
      key_valid = 1'b1;
      key_code  = d;
      tick();
      key_valid = 1'b0;
      $display("key %h: bits=%h input_value=%b store_value=%b", d, bits, input_value, store_value);
      check_eq("digit_bits", bits, exp_bits);
      check_eq("digit_input_value", input_value, exp_in);
      check_eq("digit_store_value", store_value, exp_st);
      tick();
      check_eq("strobe_one_cycle", input_value | store_value, 0);
   endtask

   task automatic press_key(input logic [3:0] k);
      key_valid = 1'b1;
      key_code  = k;
      tick();
      key_valid = 1'b0;
   endtask

   // ENTER, two compare cycles, then resp: 0 none, 1 correct, 2 incorrect.
   task automatic attempt(input int resp, output int n);
      press_key(KEY_ENTER);
      check_eq("compare_c1", compare, 1);
      tick();
      check_eq("compare_c2", compare, 1);
      tick();
      check_eq("compare_off", compare, 0);
      correct_password   = (resp == 1);
      incorrect_password = (resp == 2);
      n = 0;
      do begin
         tick();
         n++;
      end while (clear_n && n < 8);
      correct_password   = 1'b0;
      incorrect_password = 1'b0;
      $display("attempt resp=%0d: %0d result cycles, fail_count=%0d", resp, n, fail_count);
   endtask

   initial begin
      int n;
      logic seen;
      input_reset        = 1'b0;
      key_valid          = 1'b0;
      key_code           = 4'h0;
      correct_password   = 1'b0;
      incorrect_password = 1'b0;
      tick();
      tick();
      check_eq("rst_bits", bits, 0);
      check_eq("rst_strobes", {input_value, store_value, compare}, 0);
      check_eq("rst_clear_n", clear_n, 0);
      check_eq("rst_status", {unlocked, locked_out}, 0);
      check_eq("rst_fail", fail_count, 0);
      input_reset = 1'b1;
      tick();
      check_eq("rst_release_clear_n", clear_n, 1);

      // Correct four-digit code unlocks for exactly 20 cycles.
      press_digit(4'h1, 4'h1, 1, 0);
      press_digit(4'h2, 4'h2, 1, 0);
      press_digit(4'h3, 4'h3, 1, 0);
      press_digit(4'h4, 4'h4, 1, 0);
      attempt(1, n);
      check_eq("ok_latency", n, 1);
      check_eq("ok_unlocked", unlocked, 1);
      check_eq("ok_fail", fail_count, 0);
      n = 0;
      while (unlocked && n < 100) begin
         n++;
         tick();
      end
      check_eq("unlock_len", n, 20);

      // Three failures (second by checker timeout) then a 30-cycle lockout.
      for (int i = 1; i <= 3; i++) begin
         press_digit(4'h9, 4'h9, 1, 0);
         attempt((i == 2) ? 0 : 2, n);
         check_eq("fail_latency", n, (i == 2) ? 4 : 1);
         check_eq("fail_count", fail_count, i);
         check_eq("fail_locked", locked_out, (i == 3) ? 1 : 0);
      end
      n = 0;
      seen = 1'b0;
      while (locked_out && n < 200) begin
         key_valid = (n % 2 == 0);
         key_code  = (n % 4 == 0) ? 4'h5 : KEY_ENTER;
         tick();
         n++;
         seen = seen | input_value | compare | unlocked;
      end
      key_valid = 1'b0;
      check_eq("lockout_len", n, 30);
      check_eq("lockout_keys_ignored", seen, 0);
      check_eq("lockout_fail_cleared", fail_count, 0);

      // Fifth digit is refused and bits keeps the fourth.
      press_digit(4'h5, 4'h5, 1, 0);
      press_digit(4'h6, 4'h6, 1, 0);
      press_digit(4'h7, 4'h7, 1, 0);
      press_digit(4'h8, 4'h8, 1, 0);
      press_digit(4'h9, 4'h8, 0, 0);

      press_key(KEY_CLEAR);
      check_eq("clear_low", clear_n, 0);
      tick();
      check_eq("clear_high", clear_n, 1);

      // Key held into the strobe cycle is dropped.
      key_valid = 1'b1;
      key_code  = 4'h1;
      tick();
      check_eq("drop_first", input_value, 1);
      key_code = 4'h2;
      tick();
      key_valid = 1'b0;
      check_eq("drop_no_strobe", input_value, 0);
      check_eq("drop_bits", bits, 4'h1);
      tick();
      check_eq("drop_quiet", input_value, 0);

      press_key(KEY_CLEAR);
      check_eq("clear2_low", clear_n, 0);
      tick();
      check_eq("clear2_high", clear_n, 1);
      press_key(KEY_ENTER);
      check_eq("enter_empty_c1", compare, 0);
      tick();
      check_eq("enter_empty_c2", compare, 0);

      // Unlock, then program a new code.
      press_digit(4'h4, 4'h4, 1, 0);
      attempt(1, n);
      check_eq("ok2_unlocked", unlocked, 1);
      tick();
      press_key(KEY_PROG);
      check_eq("prog_clear_low", clear_n, 0);
      check_eq("prog_unlocked_off", unlocked, 0);
      tick();
      check_eq("prog_clear_high", clear_n, 1);
      press_digit(4'h7, 4'h7, 0, 1);
      press_digit(4'h3, 4'h3, 0, 1);
      press_key(KEY_ENTER);
      check_eq("prog_no_compare1", compare, 0);
      tick();
      check_eq("prog_no_compare2", compare, 0);
      press_digit(4'h2, 4'h2, 1, 0);

      // Reset in the middle of a lockout.
      for (int i = 0; i < 3; i++) begin
         press_digit(4'h6, 4'h6, 1, 0);
         attempt(2, n);
      end
      check_eq("lock2_locked", locked_out, 1);
      for (int i = 0; i < 5; i++) tick();
      input_reset = 1'b0;
      #1;
      check_eq("async_locked", locked_out, 0);
      check_eq("async_fail", fail_count, 0);
      check_eq("async_clear_n", clear_n, 0);
      check_eq("async_bits", bits, 0);
      check_eq("async_misc", {unlocked, input_value, store_value, compare}, 0);
      tick();
      check_eq("hold_clear_n", clear_n, 0);
      input_reset = 1'b1;
      tick();
      check_eq("release_clear_n", clear_n, 1);
      check_eq("release_locked", locked_out, 0);
      press_digit(4'h3, 4'h3, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
